// File: rtl/astar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : astar_pkg                                                  |
// | Shared types and default widths for the A* open-list search engine. |
// | Revision: 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package astar_pkg;

  localparam int DEF_COORD_W = 8;
  localparam int DEF_COST_W  = 12;
  localparam int DEF_DEPTH   = 400;
  localparam int DEF_LANES   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } search_state_e;

  typedef enum logic {
    MODE_MATCH = 1'b0,
    MODE_MIN   = 1'b1
  } search_mode_e;

endpackage
`default_nettype wire

// File: rtl/open_search_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : open_search_lane                                          |
// | One open-list entry comparator: coordinate equality against the     |
// | search key and cost less-than against a reference cost.             |
// | Revision: 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module open_search_lane
  import astar_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int COST_W  = DEF_COST_W
) (
  input  logic               valid,
  input  logic [COORD_W-1:0] entry_x,
  input  logic [COORD_W-1:0] entry_y,
  input  logic [COST_W-1:0]  entry_cost,
  input  logic [COORD_W-1:0] key_x,
  input  logic [COORD_W-1:0] key_y,
  input  logic               ref_valid,
  input  logic [COST_W-1:0]  ref_cost,
  output logic               hit,
  output logic               cost_lt
);

  // Entry matches the key coordinate
  assign hit = valid && (entry_x == key_x) && (entry_y == key_y);

  // Entry beats the reference (any valid entry beats an empty reference)
  assign cost_lt = valid && (!ref_valid || (entry_cost < ref_cost));

endmodule
`default_nettype wire

// File: rtl/open_list_search.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : open_list_search                                          |
// | Compact open list with append / swap-delete and a LANES-wide scan   |
// | that finds a coordinate (MATCH) or the lowest f-cost (MIN).         |
// | Optional: define OPEN_SEARCH_MIN_EN to build the MIN-cost search.   |
// | Revision: 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module open_list_search
  import astar_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int COST_W  = DEF_COST_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LANES   = DEF_LANES
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       wr_en,
  input  logic [COORD_W-1:0]         wr_x,
  input  logic [COORD_W-1:0]         wr_y,
  input  logic [COST_W-1:0]          wr_cost,
  input  logic                       del_en,
  input  logic [$clog2(DEPTH)-1:0]   del_idx,
  input  logic                       start,
  input  logic                       mode,
  input  logic [COORD_W-1:0]         key_x,
  input  logic [COORD_W-1:0]         key_y,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [$clog2(DEPTH)-1:0]   match_idx,
  output logic [COORD_W-1:0]         match_x,
  output logic [COORD_W-1:0]         match_y,
  output logic [COST_W-1:0]          match_cost,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BASE_W = $clog2(DEPTH + LANES + 1);
  localparam int EXT_W  = BASE_W + 1;

  search_state_e      state_q, state_d;
  search_mode_e       mode_q, mode_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [COORD_W-1:0] key_x_q, key_x_d, key_y_q, key_y_d;
  logic               done_q, done_d, found_q, found_d;
  logic [IDX_W-1:0]   match_idx_q, match_idx_d;
  logic [COORD_W-1:0] match_x_q, match_x_d, match_y_q, match_y_d;
  logic [COST_W-1:0]  match_cost_q, match_cost_d;

  // Entry storage (not reset; only indices below count are meaningful)
  logic [COORD_W-1:0] mem_x_q    [DEPTH];
  logic [COORD_W-1:0] mem_y_q    [DEPTH];
  logic [COST_W-1:0]  mem_cost_q [DEPTH];

  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr, last_idx;
  logic [COORD_W-1:0] mem_wx, mem_wy;
  logic [COST_W-1:0]  mem_wcost;

  logic [LANES-1:0]   lane_valid, lane_hit, lane_lt;
  logic [IDX_W-1:0]   lane_addr [LANES];
  logic [COORD_W-1:0] lane_x    [LANES];
  logic [COORD_W-1:0] lane_y    [LANES];
  logic [COST_W-1:0]  lane_cost [LANES];
  logic               ref_valid;
  logic [COST_W-1:0]  ref_cost;

  logic               last_grp;
  logic               grp_hit;
  logic [IDX_W-1:0]   grp_hit_idx;
  logic [COORD_W-1:0] grp_hit_x, grp_hit_y;
  logic [COST_W-1:0]  grp_hit_cost;

  assign last_idx = IDX_W'(count_q - CNT_W'(1));
  assign last_grp = ({1'b0, base_q} + EXT_W'(LANES)) >= EXT_W'(count_q);

  // One comparator per lane over the current group, masked to index < count
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BASE_W-1:0] idx;
    assign idx           = base_q + BASE_W'(l);
    assign lane_valid[l] = idx < BASE_W'(count_q);
    assign lane_addr[l]  = lane_valid[l] ? idx[IDX_W-1:0] : '0;
    assign lane_x[l]     = mem_x_q[lane_addr[l]];
    assign lane_y[l]     = mem_y_q[lane_addr[l]];
    assign lane_cost[l]  = mem_cost_q[lane_addr[l]];

    open_search_lane #(
      .COORD_W (COORD_W),
      .COST_W  (COST_W)
    ) u_lane (
      .valid      (lane_valid[l]),
      .entry_x    (lane_x[l]),
      .entry_y    (lane_y[l]),
      .entry_cost (lane_cost[l]),
      .key_x      (key_x_q),
      .key_y      (key_y_q),
      .ref_valid  (ref_valid),
      .ref_cost   (ref_cost),
      .hit        (lane_hit[l]),
      .cost_lt    (lane_lt[l])
    );
  end

  // Lowest-index coordinate hit within the group (descending walk, last write wins)
  always_comb begin
    grp_hit      = 1'b0;
    grp_hit_idx  = '0;
    grp_hit_x    = '0;
    grp_hit_y    = '0;
    grp_hit_cost = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (lane_hit[l]) begin
        grp_hit      = 1'b1;
        grp_hit_idx  = lane_addr[l];
        grp_hit_x    = lane_x[l];
        grp_hit_y    = lane_y[l];
        grp_hit_cost = lane_cost[l];
      end
    end
  end

`ifdef OPEN_SEARCH_MIN_EN
  logic               best_valid_q, best_valid_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [COORD_W-1:0] best_x_q, best_x_d, best_y_q, best_y_d;
  logic [COST_W-1:0]  best_cost_q, best_cost_d;
  logic               grp_min_valid;
  logic [IDX_W-1:0]   grp_min_idx;
  logic [COORD_W-1:0] grp_min_x, grp_min_y;
  logic [COST_W-1:0]  grp_min_cost;

  // Lanes compare against the running best, so a tie never displaces an earlier index
  assign ref_valid = best_valid_q;
  assign ref_cost  = best_cost_q;

  // Cheapest lane that beats the running best; ascending walk keeps the lowest index on ties
  always_comb begin
    grp_min_valid = 1'b0;
    grp_min_idx   = '0;
    grp_min_x     = '0;
    grp_min_y     = '0;
    grp_min_cost  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_lt[l] && (!grp_min_valid || (lane_cost[l] < grp_min_cost))) begin
        grp_min_valid = 1'b1;
        grp_min_idx   = lane_addr[l];
        grp_min_x     = lane_x[l];
        grp_min_y     = lane_y[l];
        grp_min_cost  = lane_cost[l];
      end
    end
  end
`else
  logic unused_lane_lt;

  assign ref_valid      = 1'b0;
  assign ref_cost       = '0;
  assign unused_lane_lt = ^lane_lt;
`endif

  // Next-state, list maintenance and result capture
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    count_d      = count_q;
    base_d       = base_q;
    key_x_d      = key_x_q;
    key_y_d      = key_y_q;
    done_d       = 1'b0;
    found_d      = found_q;
    match_idx_d  = match_idx_q;
    match_x_d    = match_x_q;
    match_y_d    = match_y_q;
    match_cost_d = match_cost_q;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wx       = wr_x;
    mem_wy       = wr_y;
    mem_wcost    = wr_cost;
`ifdef OPEN_SEARCH_MIN_EN
    best_valid_d = best_valid_q;
    best_idx_d   = best_idx_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    best_cost_d  = best_cost_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          mode_d  = search_mode_e'(mode);
          key_x_d = key_x;
          key_y_d = key_y;
          base_d  = '0;
`ifdef OPEN_SEARCH_MIN_EN
          best_valid_d = 1'b0;
`endif
        end else if (del_en) begin
          // Delete wins over a same-cycle write; last entry fills the hole
          if (CNT_W'(del_idx) < count_q) begin
            mem_we    = 1'b1;
            mem_waddr = del_idx;
            mem_wx    = mem_x_q[last_idx];
            mem_wy    = mem_y_q[last_idx];
            mem_wcost = mem_cost_q[last_idx];
            count_d   = count_q - CNT_W'(1);
          end
        end else if (wr_en && !full) begin
          mem_we    = 1'b1;
          mem_waddr = IDX_W'(count_q);
          count_d   = count_q + CNT_W'(1);
        end
      end
      ST_SCAN: begin
        if (mode_q == MODE_MATCH) begin
          if (grp_hit) begin
            state_d      = ST_DONE;
            found_d      = 1'b1;
            match_idx_d  = grp_hit_idx;
            match_x_d    = grp_hit_x;
            match_y_d    = grp_hit_y;
            match_cost_d = grp_hit_cost;
          end else if (last_grp) begin
            state_d = ST_DONE;
            found_d = 1'b0;
          end else begin
            base_d = base_q + BASE_W'(LANES);
          end
        end else begin
`ifdef OPEN_SEARCH_MIN_EN
          if (grp_min_valid) begin
            best_valid_d = 1'b1;
            best_idx_d   = grp_min_idx;
            best_x_d     = grp_min_x;
            best_y_d     = grp_min_y;
            best_cost_d  = grp_min_cost;
          end
          if (last_grp) begin
            state_d = ST_DONE;
            found_d = best_valid_d;
            if (best_valid_d) begin
              match_idx_d  = best_idx_d;
              match_x_d    = best_x_d;
              match_y_d    = best_y_d;
              match_cost_d = best_cost_d;
            end
          end else begin
            base_d = base_q + BASE_W'(LANES);
          end
`else
          // MIN search not built: finish immediately with nothing found
          state_d = ST_DONE;
          found_d = 1'b0;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_MATCH;
      count_q      <= '0;
      base_q       <= '0;
      key_x_q      <= '0;
      key_y_q      <= '0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      match_idx_q  <= '0;
      match_x_q    <= '0;
      match_y_q    <= '0;
      match_cost_q <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      count_q      <= count_d;
      base_q       <= base_d;
      key_x_q      <= key_x_d;
      key_y_q      <= key_y_d;
      done_q       <= done_d;
      found_q      <= found_d;
      match_idx_q  <= match_idx_d;
      match_x_q    <= match_x_d;
      match_y_q    <= match_y_d;
      match_cost_q <= match_cost_d;
    end
  end

`ifdef OPEN_SEARCH_MIN_EN
  // Running minimum carried across groups
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_cost_q  <= '0;
    end else begin
      best_valid_q <= best_valid_d;
      best_idx_q   <= best_idx_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      best_cost_q  <= best_cost_d;
    end
  end
`endif

  // Entry storage write port (append or swap-delete)
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_x_q[mem_waddr]    <= mem_wx;
      mem_y_q[mem_waddr]    <= mem_wy;
      mem_cost_q[mem_waddr] <= mem_wcost;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign found      = found_q;
  assign match_idx  = match_idx_q;
  assign match_x    = match_x_q;
  assign match_y    = match_y_q;
  assign match_cost = match_cost_q;
  assign count      = count_q;
  assign full       = (count_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_open_list_search.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_open_list_search                                       |
// | Directed self-checking bench for open_list_search (DEPTH=10, so the |
// | last group is partial). MIN checks follow OPEN_SEARCH_MIN_EN.       |
// | Revision: 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_open_list_search;

  localparam int COORD_W = 8;
  localparam int COST_W  = 12;
  localparam int DEPTH   = 10;
  localparam int LANES   = 4;
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b0;
  logic               wr_en = 1'b0, del_en = 1'b0, start = 1'b0, mode = 1'b0;
  logic [COORD_W-1:0] wr_x = '0, wr_y = '0, key_x = '0, key_y = '0;
  logic [COST_W-1:0]  wr_cost = '0;
  logic [IDX_W-1:0]   del_idx = '0;
  logic               busy, done, found, full;
  logic [IDX_W-1:0]   match_idx;
  logic [COORD_W-1:0] match_x, match_y;
  logic [COST_W-1:0]  match_cost;
  logic [CNT_W-1:0]   count;

  int vectors = 0;
  int miscompares = 0;

  open_list_search #(
    .COORD_W (COORD_W),
    .COST_W  (COST_W),
    .DEPTH   (DEPTH),
    .LANES   (LANES)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_cost    (wr_cost),
    .del_en     (del_en),
    .del_idx    (del_idx),
    .start      (start),
    .mode       (mode),
    .key_x      (key_x),
    .key_y      (key_y),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .match_idx  (match_idx),
    .match_x    (match_x),
    .match_y    (match_y),
    .match_cost (match_cost),
    .count      (count),
    .full       (full)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    #2 Reset_n = 1'b1;
    tick();
  endtask

  task automatic insert(input int x, input int y, input int c);
    wr_x = COORD_W'(x); wr_y = COORD_W'(y); wr_cost = COST_W'(c);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic remove(input int idx);
    del_idx = IDX_W'(idx);
    del_en = 1'b1;
    tick();
    del_en = 1'b0;
  endtask

  // Entries i = (i, 20+i, cost 100+i)
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) insert(i, 20 + i, 100 + i);
  endtask

  // Pulse start, scramble key/mode afterwards, return cycles until done (-1 on timeout)
  task automatic run_search(input int kx, input int ky, input logic m, output int lat);
    key_x = COORD_W'(kx); key_y = COORD_W'(ky); mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    key_x = ~key_x; key_y = ~key_y; mode = ~m;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset.count got=%0d exp=0", count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset.busy got=%0b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset.done got=%0b exp=0", done); end
    vectors++; if (found !== 1'b0) begin miscompares++; $display("FAIL reset.found got=%0b exp=0", found); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset.full got=%0b exp=0", full); end
    vectors++; if ({match_idx, match_x, match_y, match_cost} !== '0) begin miscompares++; $display("FAIL reset.match got=%0h exp=0", {match_idx, match_x, match_y, match_cost}); end
  endtask

  task automatic test_match_basic();
    int lat;
    insert(3, 4, 5); insert(7, 7, 2); insert(3, 4, 9);
    vectors++; if (count !== 3) begin miscompares++; $display("FAIL basic.count got=%0d exp=3", count); end
    run_search(3, 4, 1'b0, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL basic.latency got=%0d exp=2", lat); end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL basic.found got=%0b exp=1", found); end
    vectors++; if (match_idx !== 0) begin miscompares++; $display("FAIL basic.idx got=%0d exp=0", match_idx); end
    vectors++; if (match_cost !== 5) begin miscompares++; $display("FAIL basic.cost got=%0d exp=5", match_cost); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic.busy_at_done got=%0b exp=0", busy); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic.done_pulse got=%0b exp=0", done); end
    vectors++; if (found !== 1'b1 || match_idx !== 0) begin miscompares++; $display("FAIL basic.hold got=%0b/%0d exp=1/0", found, match_idx); end
    run_search(7, 7, 1'b0, lat);
    vectors++; if (lat !== 2 || found !== 1'b1 || match_idx !== 1 || match_cost !== 2) begin miscompares++; $display("FAIL basic.second got lat=%0d f=%0b idx=%0d c=%0d exp 2/1/1/2", lat, found, match_idx, match_cost); end
  endtask

  task automatic test_match_groups();
    int lat;
    apply_reset();
    fill(9);
    insert(50, 60, 77);
    vectors++; if (count !== 10 || full !== 1'b1) begin miscompares++; $display("FAIL groups.fill got=%0d/%0b exp=10/1", count, full); end
    run_search(50, 60, 1'b0, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL groups.lat_idx9 got=%0d exp=4", lat); end
    vectors++; if (found !== 1'b1 || match_idx !== 9 || match_cost !== 77) begin miscompares++; $display("FAIL groups.idx9 got f=%0b idx=%0d c=%0d exp 1/9/77", found, match_idx, match_cost); end
    run_search(5, 25, 1'b0, lat);
    vectors++; if (lat !== 3 || match_idx !== 5 || match_cost !== 105) begin miscompares++; $display("FAIL groups.idx5 got lat=%0d idx=%0d c=%0d exp 3/5/105", lat, match_idx, match_cost); end
    run_search(99, 99, 1'b0, lat);
    vectors++; if (lat !== 4 || found !== 1'b0) begin miscompares++; $display("FAIL groups.absent got lat=%0d f=%0b exp 4/0", lat, found); end
    vectors++; if (match_idx !== 5 || match_x !== 5 || match_y !== 25) begin miscompares++; $display("FAIL groups.absent_hold got %0d/%0d/%0d exp 5/5/25", match_idx, match_x, match_y); end
  endtask

  task automatic test_full();
    int lat;
    insert(1, 1, 1);
    vectors++; if (count !== 10 || full !== 1'b1) begin miscompares++; $display("FAIL full.write_ignored got=%0d/%0b exp=10/1", count, full); end
    remove(0);
    vectors++; if (count !== 9 || full !== 1'b0) begin miscompares++; $display("FAIL full.delete got=%0d/%0b exp=9/0", count, full); end
    run_search(50, 60, 1'b0, lat);
    vectors++; if (lat !== 2 || found !== 1'b1 || match_idx !== 0 || match_cost !== 77) begin miscompares++; $display("FAIL full.moved got lat=%0d f=%0b idx=%0d c=%0d exp 2/1/0/77", lat, found, match_idx, match_cost); end
    run_search(0, 20, 1'b0, lat);
    vectors++; if (lat !== 4 || found !== 1'b0) begin miscompares++; $display("FAIL full.deleted_gone got lat=%0d f=%0b exp 4/0", lat, found); end
  endtask

  task automatic test_back_to_back();
    int lat;
    // List: 0=(50,60,77), i=(i,20+i,100+i) for i=1..8
    wr_x = 8'd88; wr_y = 8'd88; wr_cost = 12'd1; wr_en = 1'b1;
    del_idx = 4'd2; del_en = 1'b1;
    tick();
    wr_en = 1'b0; del_en = 1'b0;
    vectors++; if (count !== 8) begin miscompares++; $display("FAIL b2b.count_simul got=%0d exp=8", count); end
    run_search(8, 28, 1'b0, lat);
    vectors++; if (lat !== 2 || match_idx !== 2 || match_cost !== 108) begin miscompares++; $display("FAIL b2b.swap got lat=%0d idx=%0d c=%0d exp 2/2/108", lat, match_idx, match_cost); end
    run_search(88, 88, 1'b0, lat);
    vectors++; if (lat !== 3 || found !== 1'b0) begin miscompares++; $display("FAIL b2b.write_dropped got lat=%0d f=%0b exp 3/0", lat, found); end
    remove(9);
    vectors++; if (count !== 8) begin miscompares++; $display("FAIL b2b.del_out_of_range got=%0d exp=8", count); end
    // Writes and deletes presented while busy must be dropped
    key_x = 8'd3; key_y = 8'd23; mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b.busy got=%0b exp=1", busy); end
    wr_x = 8'd66; wr_y = 8'd66; wr_en = 1'b1; del_idx = '0; del_en = 1'b1;
    tick();
    wr_en = 1'b0; del_en = 1'b0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      if (done) begin lat = c; break; end
      tick();
    end
    vectors++; if (lat !== 1 || found !== 1'b1 || match_idx !== 3) begin miscompares++; $display("FAIL b2b.busy_search got wait=%0d f=%0b idx=%0d exp 1/1/3", lat, found, match_idx); end
    vectors++; if (count !== 8) begin miscompares++; $display("FAIL b2b.busy_count got=%0d exp=8", count); end
    run_search(66, 66, 1'b0, lat);
    vectors++; if (found !== 1'b0) begin miscompares++; $display("FAIL b2b.busy_write got f=%0b exp 0", found); end
    run_search(50, 60, 1'b0, lat);
    vectors++; if (found !== 1'b1 || match_idx !== 0) begin miscompares++; $display("FAIL b2b.busy_delete got f=%0b idx=%0d exp 1/0", found, match_idx); end
  endtask

  task automatic test_min();
    int lat;
    apply_reset();
    run_search(0, 0, 1'b0, lat);
    vectors++; if (lat !== 2 || found !== 1'b0) begin miscompares++; $display("FAIL min.empty_match got lat=%0d f=%0b exp 2/0", lat, found); end
    run_search(0, 0, 1'b1, lat);
    vectors++; if (lat !== 2 || found !== 1'b0) begin miscompares++; $display("FAIL min.empty_min got lat=%0d f=%0b exp 2/0", lat, found); end
    insert(1, 1, 8); insert(2, 2, 3); insert(3, 3, 3); insert(4, 4, 6);
    run_search(0, 0, 1'b1, lat);
`ifdef OPEN_SEARCH_MIN_EN
    vectors++; if (lat !== 2 || found !== 1'b1 || match_idx !== 1 || match_cost !== 3 || match_x !== 2) begin miscompares++; $display("FAIL min.tie got lat=%0d f=%0b idx=%0d c=%0d exp 2/1/1/3", lat, found, match_idx, match_cost); end
    insert(5, 5, 2); insert(6, 6, 2);
    run_search(0, 0, 1'b1, lat);
    vectors++; if (lat !== 3 || match_idx !== 4 || match_cost !== 2) begin miscompares++; $display("FAIL min.groups got lat=%0d idx=%0d c=%0d exp 3/4/2", lat, match_idx, match_cost); end
`else
    vectors++; if (lat !== 2 || found !== 1'b0) begin miscompares++; $display("FAIL min.disabled got lat=%0d f=%0b exp 2/0", lat, found); end
`endif
    run_search(4, 4, 1'b0, lat);
    vectors++; if (found !== 1'b1 || match_idx !== 3 || match_cost !== 6) begin miscompares++; $display("FAIL min.cost_kept got f=%0b idx=%0d c=%0d exp 1/3/6", found, match_idx, match_cost); end
  endtask

  task automatic test_reset_mid_scan();
    apply_reset();
    fill(10);
    key_x = 8'd99; key_y = 8'd99; mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst.busy_before got=%0b exp=1", busy); end
    #1 Reset_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || count !== 0 || done !== 1'b0) begin miscompares++; $display("FAIL midrst.state got busy=%0b cnt=%0d done=%0b exp 0/0/0", busy, count, done); end
    tick();
    #2 Reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst.no_done got done=%0b busy=%0b exp 0/0", done, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_match_basic();
    test_match_groups();
    test_full();
    test_back_to_back();
    test_min();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
